memory_reader_input: RTL and testbench
======================================

Name: memory_reader_input

Overview:
- AXI4 read-side counterpart of the block-ordered frame writer.
- Fetches one frame from external memory, where it is stored raster-ordered at one pixel per DATA_WIDTH word, and replays it as a block-ordered pixel stream: BLOCK_SIZE x BLOCK_SIZE blocks, left-to-right then top-to-bottom, rows inside each block.
- Acts as the AXI read master: one INCR burst per block row. Feeds the Wiener/processing pipeline.

Parameters:
- DATA_WIDTH, 32, AXI data and pixel word width.
- ADDR_WIDTH, 32, AXI address width.
- BLOCK_SIZE, 8, block edge in pixels; also the burst length in beats.
- BYTES_PER_PIXEL, 4, address stride per pixel; equals DATA_WIDTH/8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start_frame  in  1  one-cycle pulse; starts a frame read
- base_addr  in  ADDR_WIDTH  frame base byte address
- frame_width  in  16  pixels per line, multiple of BLOCK_SIZE
- frame_height  in  16  lines, multiple of BLOCK_SIZE
- araddr  out  ADDR_WIDTH  AR address
- arlen  out  8  AR burst length, constant BLOCK_SIZE-1
- arsize  out  3  constant log2(BYTES_PER_PIXEL)
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_WIDTH  R data
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- pixel_out  out  DATA_WIDTH  output pixel
- pixel_valid  out  1  pixel_out valid
- pixel_ready  in  1  downstream accepts pixel
- start_block  out  1  one-cycle pulse before each block's first pixel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel of the frame
- burst_err  out  1  sticky rlast mismatch flag
- stall_cycles  out  32  backpressure counter (optional feature)

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - arvalid, rready, pixel_valid, start_block, busy, frame_done and burst_err all go to 0.
  - araddr, stall_cycles and all counters go to 0.
  - Reset mid-frame aborts immediately with no drain; the AXI slave must be reset together with this block.
- IDLE:
  - start_frame latches base_addr, frame_width and frame_height, clears burst_err, sets busy, and moves to START_BLK.
  - start_frame is ignored while busy.
  - If frame_width or frame_height is less than BLOCK_SIZE, go to DONE with no AXI traffic.
- START_BLK (1 cycle): start_block=1, then ADDR.
- ADDR:
  - arvalid=1 with araddr = base + ((by*BLOCK_SIZE + r)*frame_width + bx*BLOCK_SIZE)*BYTES_PER_PIXEL.
  - bx/by are block column/row, r is the row within the block.
  - Arithmetic is done at ADDR_WIDTH and truncated.
  - araddr and arvalid are held stable until arready; the handshake cycle moves to DATA.
- DATA:
  - pixel_out=rdata, pixel_valid=rvalid, rready=pixel_ready. This is a combinational pass-through with zero latency.
  - A beat is consumed when rvalid and rready are both high; the beat counter counts 0..BLOCK_SIZE-1.
  - The beat count is authoritative. If rlast is set on a beat other than BLOCK_SIZE-1, or is missing on beat BLOCK_SIZE-1, burst_err is set (sticky) and the burst still completes on the count.
  - After the last beat:
    - r < BLOCK_SIZE-1: increment r and return to ADDR.
    - Else, bx < blocks_x-1: increment bx, r=0, go to START_BLK.
    - Else, by < blocks_y-1: bx=0, increment by, go to START_BLK.
    - Else go to DONE.
- DONE (1 cycle): frame_done=1, busy=0, then IDLE.
- Only one outstanding AR at a time.
- Outside DATA, pixel_valid and rready are 0.
- start_block and frame_done never coincide with pixel_valid.

Optional Feature:
- Macro READER_STALL_CNT_EN.
- Defined: stall_cycles increments (saturating at 2^32-1) every cycle with pixel_valid=1 and pixel_ready=0. It is cleared on reset and on an accepted start_frame.
- Undefined: stall_cycles is tied to 0 and no counter is synthesized.

Test Plan:
- 16x16 frame, base 0x0, memory word i = i, pixel_ready=1 → 4 start_block pulses, 32 ARs, 256 beats, one frame_done, burst_err=0.
  - First ARs: 0x000, 0x040, 0x080, ...; block 1 row 0 at 0x020; block 2 row 0 at 0x200.
  - Pixel order 0..7, 16..23, ..., 112..119, then 8..15, ...
- Slave holds arready low 5 cycles on the first AR → araddr=0x000 and arvalid stay stable for all 5 cycles; output order unchanged.
- pixel_ready toggles 1,0,1,0 during the 16x16 frame → rready mirrors pixel_ready; 256 pixels in correct order. With READER_STALL_CNT_EN, stall_cycles equals the count of valid&&!ready cycles.
- Slave asserts rlast on beat 3 of the first burst → burst_err=1 and stays 1; frame still outputs 256 pixels; the next start_frame clears burst_err.
- Reset mid-frame after 100 beats, then start_frame with an 8x8 frame at base 0x100 → all outputs 0 after reset; 8 ARs at 0x100, 0x120, ..., 0x1E0; frame_done once.
- start_frame while busy, and a frame_width=4 frame → busy start ignored; width-4 frame gives frame_done 2 cycles after start_frame with no arvalid.

Source files
------------

// File: rtl/memory_reader_input.sv
// AXI4 read master that fetches a raster-stored frame one block row per burst and
// replays it block-ordered. Optional stall counter enabled by READER_STALL_CNT_EN.
module memory_reader_input #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int BLOCK_SIZE      = 8,
  parameter int BYTES_PER_PIXEL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_frame,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  start_block,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  burst_err,
  output logic [31:0]           stall_cycles
);

  localparam int BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);
  localparam logic [15:0] BS16 = 16'(BLOCK_SIZE);
  localparam logic [16:0] BS17 = 17'(BLOCK_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BLK,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [15:0]           width_q, width_d;
  logic [15:0]           height_q, height_d;
  logic [15:0]           x_q, x_d;
  logic [15:0]           y_q, y_d;
  logic [BEAT_W-1:0]     r_q, r_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  beat_fire;
  logic                  last_beat;
  logic [16:0]           x_next;
  logic [16:0]           y_next;
  logic [ADDR_WIDTH-1:0] line_a;
  logic [ADDR_WIDTH-1:0] pix_a;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    araddr_d = araddr_q;
    width_d  = width_q;
    height_d = height_q;
    x_d      = x_q;
    y_d      = y_q;
    r_d      = r_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    err_d    = err_q;

    beat_fire = (state_q == S_DATA) && rvalid && pixel_ready;
    last_beat = (beat_q == LAST_BEAT);
    x_next    = {1'b0, x_q} + BS17;
    y_next    = {1'b0, y_q} + BS17;

    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          base_d   = base_addr;
          width_d  = frame_width;
          height_d = frame_height;
          x_d      = '0;
          y_d      = '0;
          r_d      = '0;
          beat_d   = '0;
          err_d    = 1'b0;
          // A frame smaller than one block has nothing to fetch
          if ((frame_width < BS16) || (frame_height < BS16)) begin
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_START_BLK;
          end
        end
      end
      S_START_BLK: state_d = S_ADDR;
      S_ADDR: begin
        if (arready) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_fire) begin
          // The beat counter decides burst end; rlast is only cross-checked
          if (rlast != last_beat) err_d = 1'b1;
          if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else begin
            beat_d = '0;
            if (r_q != LAST_BEAT) begin
              r_d     = r_q + 1'b1;
              state_d = S_ADDR;
            end else if (x_next < {1'b0, width_q}) begin
              x_d     = x_q + BS16;
              r_d     = '0;
              state_d = S_START_BLK;
            end else if (y_next < {1'b0, height_q}) begin
              x_d     = '0;
              y_d     = y_q + BS16;
              r_d     = '0;
              state_d = S_START_BLK;
            end else begin
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Loaded only on entry to ADDR so araddr stays frozen while waiting for arready
    line_a = ADDR_WIDTH'(y_d) + ADDR_WIDTH'(r_d);
    pix_a  = line_a * ADDR_WIDTH'(width_d) + ADDR_WIDTH'(x_d);
    if ((state_d == S_ADDR) && (state_q != S_ADDR)) begin
      araddr_d = base_d + pix_a * ADDR_WIDTH'(BYTES_PER_PIXEL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      araddr_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      araddr_q <= araddr_d;
      width_q  <= width_d;
      height_q <= height_d;
      x_q      <= x_d;
      y_q      <= y_d;
      r_q      <= r_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign araddr      = araddr_q;
  assign arlen       = 8'(BLOCK_SIZE - 1);
  assign arsize      = 3'($clog2(BYTES_PER_PIXEL));
  assign arburst     = 2'b01;
  assign arvalid     = (state_q == S_ADDR);
  assign rready      = (state_q == S_DATA) && pixel_ready;
  assign pixel_valid = (state_q == S_DATA) && rvalid;
  assign pixel_out   = (state_q == S_DATA) ? rdata : '0;
  assign start_block = (state_q == S_START_BLK);
  assign frame_done  = (state_q == S_DONE);
  assign busy        = busy_q;
  assign burst_err   = err_q;

`ifdef READER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start_frame) begin
      stall_d = '0;
    end else if (pixel_valid && !pixel_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_memory_reader_input.sv
// Scoreboard bench for memory_reader_input: an AXI read slave returns word (addr/4),
// expected ARs and pixels are queued at stimulus time and popped by a monitor.
`timescale 1ns/1ps
module tb_memory_reader_input;
  localparam int BS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_frame = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] frame_width = '0;
  logic [15:0] frame_height = '0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] pixel_out;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;
  logic        start_block;
  logic        busy;
  logic        frame_done;
  logic        burst_err;
  logic [31:0] stall_cycles;

  memory_reader_input dut (
    .clk(clk), .rst_n(rst_n), .start_frame(start_frame), .base_addr(base_addr),
    .frame_width(frame_width), .frame_height(frame_height),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .start_block(start_block), .busy(busy), .frame_done(frame_done),
    .burst_err(burst_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ar[$];
  logic [31:0] exp_pix[$];
  logic [31:0] ar_log[64];
  logic [31:0] pix_log[256];
  int ar_cnt, pix_cnt, sb_cnt, done_cnt, ar_seen, stall_exp, arwait_cnt;
  int ar_hold = 0;
  logic err_inject = 1'b0;
  logic tog_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ---------------- AXI read slave: word at byte address a is a/4 ----------------
  logic        s_active = 1'b0;
  int          s_beat = 0;
  logic [31:0] s_addr = '0;

  task automatic drive_beat();
    rvalid = 1'b1;
    rdata  = (s_addr >> 2) + 32'(s_beat);
    rlast  = err_inject ? (s_beat == 3) : (s_beat == BS - 1);
  endtask

  initial begin
    logic ar_fire, r_fire, s_rst, arv_smp;
    logic [31:0] a_smp;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      s_rst   = !rst_n;
      arv_smp = arvalid;
      a_smp   = araddr;
      @(posedge clk);
      #1;
      if (s_rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; s_active = 1'b0;
      end else if (ar_fire) begin
        arready  = 1'b0;
        s_active = 1'b1;
        s_addr   = a_smp;
        s_beat   = 0;
        drive_beat();
      end else if (r_fire) begin
        s_beat++;
        if (s_beat == BS) begin
          rvalid = 1'b0; rlast = 1'b0; s_active = 1'b0; err_inject = 1'b0;
        end else begin
          drive_beat();
        end
      end else if (arv_smp && !s_active && !arready) begin
        if (ar_hold > 0) ar_hold--;
        else arready = 1'b1;
      end
    end
  end

  // Downstream backpressure pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) pixel_ready = ~pixel_ready;
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  initial begin
    logic prev_wait;
    logic [31:0] prev_addr, e;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wait = 1'b0;
        continue;
      end
      if (arvalid) ar_seen++;
      if (prev_wait) begin
        check32("ar_hold_valid", arvalid, 1);
        check32("ar_hold_addr", araddr, prev_addr);
      end
      if (arvalid && !arready && ar_cnt == 0) arwait_cnt++;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) fail_now("ar_extra");
        else begin
          e = exp_ar.pop_front();
          check32("araddr", araddr, e);
        end
        if (ar_cnt < 64) ar_log[ar_cnt] = araddr;
        ar_cnt++;
      end
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      if (pixel_valid) check32("rready_mirror", rready, pixel_ready);
      if (pixel_valid && !pixel_ready) stall_exp++;
      if (pixel_valid && pixel_ready) begin
        if (exp_pix.size() == 0) fail_now("pix_extra");
        else begin
          e = exp_pix.pop_front();
          check32("pixel", pixel_out, e);
        end
        if (pix_cnt < 256) pix_log[pix_cnt] = pixel_out;
        pix_cnt++;
      end
      if (start_block) begin
        sb_cnt++;
        check32("sb_no_pix", pixel_valid, 0);
      end
      if (frame_done) begin
        done_cnt++;
        check32("done_no_pix", pixel_valid, 0);
        check32("done_busy", busy, 0);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic push_frame(input logic [31:0] b, input int w, input int h);
    for (int by = 0; by < h / BS; by++)
      for (int bx = 0; bx < w / BS; bx++)
        for (int r = 0; r < BS; r++) begin
          logic [31:0] a;
          a = b + 32'(((by * BS + r) * w + bx * BS) * 4);
          exp_ar.push_back(a);
          for (int c = 0; c < BS; c++) exp_pix.push_back((a >> 2) + 32'(c));
        end
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] w, input logic [15:0] h);
    @(posedge clk);
    #1;
    base_addr = b; frame_width = w; frame_height = h; start_frame = 1'b1;
    @(posedge clk);
    #1;
    start_frame = 1'b0;
  endtask

  task automatic run_start(input logic [31:0] b, input int w, input int h);
    ar_cnt = 0; pix_cnt = 0; sb_cnt = 0; done_cnt = 0; ar_seen = 0;
    stall_exp = 0; arwait_cnt = 0;
    push_frame(b, w, h);
    pulse_start(b, 16'(w), 16'(h));
  endtask

  task automatic wait_pix(input int n, input int budget);
    int i;
    i = 0;
    while (pix_cnt < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (pix_cnt < n) fail_now("wait_pix_timeout");
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("frame_done_once", 32'(done_cnt), 1);
  endtask

  task automatic frame_end(input int sb, input int ars, input int pix, input logic err);
    check32("start_block_cnt", 32'(sb_cnt), 32'(sb));
    check32("ar_cnt", 32'(ar_cnt), 32'(ars));
    check32("pix_cnt", 32'(pix_cnt), 32'(pix));
    check32("burst_err", burst_err, err);
    check32("busy_idle", busy, 0);
    check32("exp_ar_left", 32'(exp_ar.size()), 0);
    check32("exp_pix_left", 32'(exp_pix.size()), 0);
  endtask

  task automatic check_reset(input string tag);
    check32({tag, "_arvalid"}, arvalid, 0);
    check32({tag, "_rready"}, rready, 0);
    check32({tag, "_pixel_valid"}, pixel_valid, 0);
    check32({tag, "_start_block"}, start_block, 0);
    check32({tag, "_busy"}, busy, 0);
    check32({tag, "_frame_done"}, frame_done, 0);
    check32({tag, "_burst_err"}, burst_err, 0);
    check32({tag, "_araddr"}, araddr, 0);
    check32({tag, "_stall"}, stall_cycles, 0);
    check32({tag, "_pixel_out"}, pixel_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    check32("arlen", arlen, 7);
    check32("arsize", arsize, 2);
    check32("arburst", arburst, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: plain 16x16 frame, plus an ignored start while busy
    run_start(32'h0, 16, 16);
    @(negedge clk);
    check32("busy_set", busy, 1);
    wait_pix(20, 2000);
    pulse_start(32'h1000, 16'd8, 16'd8);
    wait_done(3000);
    frame_end(4, 32, 256, 1'b0);
    check32("ar0", ar_log[0], 32'h000);
    check32("ar1", ar_log[1], 32'h040);
    check32("ar2", ar_log[2], 32'h080);
    check32("ar8_blk1", ar_log[8], 32'h020);
    check32("ar16_blk2", ar_log[16], 32'h200);
    check32("ar31", ar_log[31], 32'h3E0);
    check32("pix0", pix_log[0], 0);
    check32("pix7", pix_log[7], 7);
    check32("pix8", pix_log[8], 16);
    check32("pix63", pix_log[63], 119);
    check32("pix64", pix_log[64], 8);
    check32("pix255", pix_log[255], 255);

    // 2: first AR held off for 5 cycles
    ar_hold = 4;
    run_start(32'h0, 16, 16);
    wait_done(3000);
    frame_end(4, 32, 256, 1'b0);
    check32("arwait_first", 32'(arwait_cnt), 5);

    // 3: downstream toggles ready every cycle
    tog_en = 1'b1;
    run_start(32'h0, 16, 16);
    wait_done(5000);
    tog_en = 1'b0;
    @(posedge clk);
    #2;
    pixel_ready = 1'b1;
    frame_end(4, 32, 256, 1'b0);
`ifdef READER_STALL_CNT_EN
    check32("stall_cycles", stall_cycles, 32'(stall_exp));
`else
    check32("stall_cycles_off", stall_cycles, 0);
`endif

    // 4: early rlast on beat 3 of the first burst
    err_inject = 1'b1;
    run_start(32'h0, 16, 16);
    wait_pix(50, 2000);
    check32("err_sticky_mid", burst_err, 1);
    wait_done(3000);
    frame_end(4, 32, 256, 1'b1);

    // 5: next start clears the error; reset mid-frame; then 8x8 at 0x100
    run_start(32'h0, 16, 16);
    @(negedge clk);
    check32("err_cleared", burst_err, 0);
    wait_pix(100, 2000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_mid");
    exp_ar.delete();
    exp_pix.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_start(32'h100, 8, 8);
    wait_done(2000);
    frame_end(1, 8, 64, 1'b0);
    for (int i = 0; i < 8; i++) check32("ar_8x8", ar_log[i], 32'h100 + 32'(i) * 32'h20);
    check32("pix_8x8_first", pix_log[0], 32'h40);
    check32("pix_8x8_last", pix_log[63], 32'h7F);

    // 6: width below one block -> immediate done, no AXI traffic
    run_start(32'h0, 4, 16);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("deg_done", 32'(done_cnt), 1);
    check32("deg_no_ar", 32'(ar_seen), 0);
    check32("deg_busy", busy, 0);
    check32("deg_no_sb", 32'(sb_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
